// File: rtl/fb_pkg.sv
// Frame-buffer scheduler shared definitions: burst/frame geometry,
// arbiter state encoding and the SDRAM burst address composer.
package fb_pkg;

    localparam int unsigned BURST_LEN  = 512;
    localparam int unsigned FRAME_ROWS = 750;
    localparam int unsigned ROW_W      = 13;
    localparam int unsigned ADDR_W     = 24;
    localparam int unsigned COL_W      = $clog2(BURST_LEN);

    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(FRAME_ROWS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY
    } fb_state_t;

    // {0, bank, row, column 0}: one burst covers exactly one SDRAM row.
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic             bank,
        input logic [ROW_W-1:0] row
    );
        return {1'b0, bank, row, {COL_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fb_row_ctr.sv
// Row/bank counter for one frame-buffer requester plus its burst address.
// Ports: restart_i applies a frame restart, toggle_i selects writer-style
// bank handling (flip only after a full frame) versus follow_bank_i,
// inc_i advances the row (saturating), load_i latches addr_o for a grant,
// row_o is the current row count.
module fb_row_ctr
    import fb_pkg::*;
(
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic              restart_i,
    input  logic              toggle_i,
    input  logic              follow_bank_i,
    input  logic              inc_i,
    input  logic              load_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic             bank_q;
    logic             full;
    logic             new_bank;
    logic             bank_eff;
    logic [ROW_W-1:0] row_eff;

    // A grant in the restart cycle must already see the restarted position.
    always_comb begin
        full     = (row_o == ROW_END);
        new_bank = toggle_i ? (bank_q ^ full) : follow_bank_i;
        bank_eff = restart_i ? new_bank : bank_q;
        row_eff  = restart_i ? '0 : row_o;
    end

    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            row_o  <= '0;
            bank_q <= 1'b0;
            addr_o <= '0;
        end else begin
            if (restart_i) begin
                row_o  <= '0;
                bank_q <= new_bank;
            end else if (inc_i && row_o < ROW_END) begin
                row_o <= row_o + 1'b1;
            end
            if (load_i) begin
                addr_o <= fb_addr(bank_eff, row_eff);
            end
        end
    end

endmodule

// File: rtl/sdram_fb_arbiter.sv
// Round-robin burst scheduler between camera writes and VGA reads with
// ping-pong frame banks in front of the single sdram_top request port.
// Ports: frame-start pulses and FIFO levels in, write/read req+addr out,
// acks in, wr_row_o progress, frame_done_o pulse, vga_en_o release.
module sdram_fb_arbiter
    import fb_pkg::*;
(
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic              wr_frame_start_i,
    input  logic              rd_frame_start_i,
    input  logic              wr_fifo_ready_i,
    input  logic              rd_fifo_space_i,
    output logic              wr_sdram_req_o,
    input  logic              wr_sdram_ack_i,
    output logic [ADDR_W-1:0] wr_sdram_add_o,
    output logic              rd_sdram_req_o,
    input  logic              rd_sdram_ack_i,
    output logic [ADDR_W-1:0] rd_sdram_add_o,
    output logic [ROW_W-1:0]  wr_row_o,
    output logic              frame_done_o,
    output logic              vga_en_o
);

    fb_state_t        state_q;
    fb_state_t        state_d;
    logic             wr_pend_q;
    logic             rd_pend_q;
    logic             last_rd_q;
    logic             done_bank_q;
    logic             frame_valid_q;
    logic             frame_done_q;
    logic             idle;
    logic             wr_apply;
    logic             rd_apply;
    logic             wr_elig;
    logic             rd_elig;
    logic             grant_wr;
    logic             grant_rd;
    logic             wr_done;
    logic             rd_done;
    logic             wr_last;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] rd_row;

    // Pending restarts (including a pulse arriving this cycle) land in
    // IDLE before arbitration so the grant uses the restarted row/bank.
    always_comb begin
        idle     = (state_q == IDLE);
        wr_apply = idle & (wr_pend_q | wr_frame_start_i);
        rd_apply = idle & (rd_pend_q | rd_frame_start_i);
        wr_elig  = wr_fifo_ready_i & (wr_apply | (wr_row < ROW_END));
        rd_elig  = frame_valid_q & rd_fifo_space_i
                 & (rd_apply | (rd_row < ROW_END));
        grant_rd = idle & rd_elig & (~wr_elig | ~last_rd_q);
        grant_wr = idle & wr_elig & ~grant_rd;
        wr_done  = (state_q == WR_BUSY) & wr_sdram_ack_i;
        rd_done  = (state_q == RD_BUSY) & rd_sdram_ack_i;
        wr_last  = wr_done & (wr_row == ROW_LAST);
    end

    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d = RD_BUSY;
                end else if (grant_wr) begin
                    state_d = WR_BUSY;
                end
            end
            WR_BUSY: if (wr_sdram_ack_i) state_d = IDLE;
            RD_BUSY: if (rd_sdram_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_sdram_req_o = 1'b0;
        rd_sdram_req_o = 1'b0;
        unique case (state_q)
            WR_BUSY: wr_sdram_req_o = 1'b1;
            RD_BUSY: rd_sdram_req_o = 1'b1;
            default: ;
        endcase
    end

    // The write address register holds the bank of the burst being acked,
    // so it names the bank that has just been completed.
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            wr_pend_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            last_rd_q     <= 1'b0;
            done_bank_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            wr_pend_q    <= (wr_pend_q | wr_frame_start_i) & ~idle;
            rd_pend_q    <= (rd_pend_q | rd_frame_start_i) & ~idle;
            frame_done_q <= wr_last;
            if (grant_wr | grant_rd) begin
                last_rd_q <= grant_rd;
            end
            if (wr_last) begin
                done_bank_q   <= wr_sdram_add_o[ADDR_W-2];
                frame_valid_q <= 1'b1;
            end
        end
    end

    fb_row_ctr u_wr_ctr (
        .clk_133M_i    (clk_133M_i),
        .rst_133i      (rst_133i),
        .restart_i     (wr_apply),
        .toggle_i      (1'b1),
        .follow_bank_i (1'b0),
        .inc_i         (wr_done),
        .load_i        (grant_wr),
        .row_o         (wr_row),
        .addr_o        (wr_sdram_add_o)
    );

    fb_row_ctr u_rd_ctr (
        .clk_133M_i    (clk_133M_i),
        .rst_133i      (rst_133i),
        .restart_i     (rd_apply),
        .toggle_i      (1'b0),
        .follow_bank_i (done_bank_q),
        .inc_i         (rd_done),
        .load_i        (grant_rd),
        .row_o         (rd_row),
        .addr_o        (rd_sdram_add_o)
    );

    assign wr_row_o     = wr_row;
    assign frame_done_o = frame_done_q;
    assign vga_en_o     = frame_valid_q;

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed bench for sdram_fb_arbiter: a burst-serving task plays the
// sdram_top side and checks grant, address, hold and release of each burst.
module tb_sdram_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_start;
    logic        rd_start;
    logic        wr_ready;
    logic        rd_space;
    logic        wr_req;
    logic        wr_ack;
    logic [23:0] wr_add;
    logic        rd_req;
    logic        rd_ack;
    logic [23:0] rd_add;
    logic [12:0] wr_row;
    logic        frame_done;
    logic        vga_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_fb_arbiter dut (
        .clk_133M_i       (clk),
        .rst_133i         (rst),
        .wr_frame_start_i (wr_start),
        .rd_frame_start_i (rd_start),
        .wr_fifo_ready_i  (wr_ready),
        .rd_fifo_space_i  (rd_space),
        .wr_sdram_req_o   (wr_req),
        .wr_sdram_ack_i   (wr_ack),
        .wr_sdram_add_o   (wr_add),
        .rd_sdram_req_o   (rd_req),
        .rd_sdram_ack_i   (rd_ack),
        .rd_sdram_add_o   (rd_add),
        .wr_row_o         (wr_row),
        .frame_done_o     (frame_done),
        .vga_en_o         (vga_en)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected burst address: bank at bit 22, row at bits [21:9].
    function automatic logic [23:0] ea(input logic bank, input int row);
        logic [23:0] a;
        logic [31:0] r;
        a = '0;
        r = row;
        a[22] = bank;
        a[21:9] = r[12:0];
        return a;
    endfunction

    // Wait (bounded) for a request, check it, hold for lat cycles, ack it
    // and check the request drops on the ack edge.
    task automatic serve(input bit rd, input logic [23:0] exp, input int lat,
                         input bit mid_wr_start, output bit fd);
        int n;
        logic [1:0] want;
        n = 0;
        want = rd ? 2'b10 : 2'b01;
        while (wr_req === 1'b0 && rd_req === 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", 32'(n < 100), 32'd1);
        check(rd ? "rd_grant" : "wr_grant", 32'({rd_req, wr_req}), 32'(want));
        check(rd ? "rd_addr" : "wr_addr", 32'(rd ? rd_add : wr_add), 32'(exp));
        if (mid_wr_start) begin
            wr_start = 1'b1;
            @(negedge clk);
            wr_start = 1'b0;
        end
        repeat (lat) @(negedge clk);
        check("req_held", 32'({rd_req, wr_req}), 32'(want));
        check("addr_held", 32'(rd ? rd_add : wr_add), 32'(exp));
        if (rd) rd_ack = 1'b1;
        else    wr_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        fd = frame_done;
        check("req_drop", 32'({rd_req, wr_req}), 32'd0);
    endtask

    initial begin
        bit fd;
        bit last_fd;
        int fd_cnt;
        logic seen;

        rst = 1'b1;
        wr_start = 1'b0;
        rd_start = 1'b0;
        wr_ready = 1'b0;
        rd_space = 1'b0;
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_add", 32'(wr_add), 32'd0);
        check("rst_rd_add", 32'(rd_add), 32'd0);
        check("rst_wr_row", 32'(wr_row), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_vga_en", 32'(vga_en), 32'd0);
        rst = 1'b0;

        // First frame: 750 writes into bank 0, ack 20 cycles after request.
        wr_ready = 1'b1;
        fd_cnt = 0;
        last_fd = 1'b0;
        for (int r = 0; r < 750; r++) begin
            serve(1'b0, ea(1'b0, r), 20, 1'b0, fd);
            fd_cnt += int'(fd);
            last_fd = fd;
            check("wr_row_inc", 32'(wr_row), 32'(r + 1));
            if (r == 748) check("vga_en_early", 32'(vga_en), 32'd0);
        end
        check("frame1_done_cnt", 32'(fd_cnt), 32'd1);
        check("frame1_done_last", 32'(last_fd), 32'd1);
        check("frame1_vga_en", 32'(vga_en), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | wr_req;
        end
        check("no_751st_write", 32'(seen), 32'd0);
        check("frame1_wr_row", 32'(wr_row), 32'd750);

        // New camera frame goes to bank 1; tie alternates starting with read.
        rd_space = 1'b1;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check("wr_restart_row", 32'(wr_row), 32'd0);
        for (int i = 0; i < 6; i++) begin
            serve(1'b1, ea(1'b0, i), 2, 1'b0, fd);
            serve(1'b0, ea(1'b1, i), 2, 1'b0, fd);
        end

        // VGA restart reads the completed bank 0 from row 0.
        wr_ready = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        serve(1'b1, ea(1'b0, 0), 2, 1'b0, fd);

        // Partial camera frame: restart during row 300 rewrites bank 1.
        rd_space = 1'b0;
        wr_ready = 1'b1;
        fd_cnt = 0;
        for (int r = 6; r < 300; r++) begin
            serve(1'b0, ea(1'b1, r), 1, 1'b0, fd);
            fd_cnt += int'(fd);
        end
        serve(1'b0, ea(1'b1, 300), 2, 1'b1, fd);
        fd_cnt += int'(fd);
        check("partial_row_301", 32'(wr_row), 32'd301);
        serve(1'b0, ea(1'b1, 0), 1, 1'b0, fd);
        fd_cnt += int'(fd);
        check("partial_row_1", 32'(wr_row), 32'd1);
        check("partial_no_done", 32'(fd_cnt), 32'd0);

        // Both frame starts in one idle cycle, then a single read grant.
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_quiet", 32'({rd_req, wr_req}), 32'd0);
        wr_start = 1'b1;
        rd_start = 1'b1;
        wr_ready = 1'b1;
        rd_space = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        rd_start = 1'b0;
        check("dual_wr_row", 32'(wr_row), 32'd0);
        check("dual_one_grant", 32'({rd_req, wr_req}), 32'b10);
        serve(1'b1, ea(1'b0, 0), 1, 1'b0, fd);
        serve(1'b0, ea(1'b1, 0), 1, 1'b0, fd);
        check("dual_wr_row_1", 32'(wr_row), 32'd1);

        // Reset during a read burst; the late ack must be ignored.
        wr_ready = 1'b0;
        @(negedge clk);
        check("rd_busy_req", 32'(rd_req), 32'd1);
        check("rd_busy_add", 32'(rd_add), 32'(ea(1'b0, 1)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rd_req", 32'(rd_req), 32'd0);
        check("rst_mid_rd_add", 32'(rd_add), 32'd0);
        check("rst_mid_vga_en", 32'(vga_en), 32'd0);
        check("rst_mid_wr_row", 32'(wr_row), 32'd0);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_no_req", 32'(rd_req), 32'd0);

        // Refill a frame; the first read must still be row 0.
        rd_space = 1'b0;
        wr_ready = 1'b1;
        fd_cnt = 0;
        for (int r = 0; r < 750; r++) begin
            serve(1'b0, ea(1'b0, r), 1, 1'b0, fd);
            fd_cnt += int'(fd);
        end
        check("frame2_done_cnt", 32'(fd_cnt), 32'd1);
        check("frame2_vga_en", 32'(vga_en), 32'd1);
        rd_space = 1'b1;
        serve(1'b1, ea(1'b0, 0), 1, 1'b0, fd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
